// File: rtl/mem_sp_stream_ctrl_if.sv
// -----------------------------------------------------------------------------
// mem_sp_stream_ctrl_if
//   Bundles every signal between the stream controller, its client (command,
//   write stream, read stream, done) and the single-ported RAM it drives.
//
//   Modports
//     slave  : controller view (takes commands and streams, drives the RAM pins)
//     master : client / RAM view (the opposite directions)
//
//   Signals
//     cmd_valid/cmd_ready/cmd_rd/cmd_base/cmd_len : block command handshake
//     wr_data/wr_valid/wr_ready                   : write data stream
//     rd_data/rd_valid/rd_ready                   : read data stream
//     done                                        : one-cycle completion pulse
//     mem_en/mem_we/mem_addr/mem_di/mem_do        : RAM pins
//     csum                                        : XOR checksum, only when
//                                                   MEM_SP_STREAM_CSUM_EN is defined
// -----------------------------------------------------------------------------
interface mem_sp_stream_ctrl_if #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 64
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic             cmd_valid;
    logic             cmd_ready;
    logic             cmd_rd;
    logic [AW-1:0]    cmd_base;
    logic [AW:0]      cmd_len;
    logic [WIDTH-1:0] wr_data;
    logic             wr_valid;
    logic             wr_ready;
    logic [WIDTH-1:0] rd_data;
    logic             rd_valid;
    logic             rd_ready;
    logic             done;
    logic             mem_en;
    logic             mem_we;
    logic [AW-1:0]    mem_addr;
    logic [WIDTH-1:0] mem_di;
    logic [WIDTH-1:0] mem_do;
`ifdef MEM_SP_STREAM_CSUM_EN
    logic [WIDTH-1:0] csum;
`endif

    modport slave (
        input  cmd_valid, cmd_rd, cmd_base, cmd_len,
        input  wr_data, wr_valid, rd_ready, mem_do,
        output cmd_ready, wr_ready, rd_data, rd_valid, done,
`ifdef MEM_SP_STREAM_CSUM_EN
        output csum,
`endif
        output mem_en, mem_we, mem_addr, mem_di
    );

    modport master (
        output cmd_valid, cmd_rd, cmd_base, cmd_len,
        output wr_data, wr_valid, rd_ready, mem_do,
        input  cmd_ready, wr_ready, rd_data, rd_valid, done,
`ifdef MEM_SP_STREAM_CSUM_EN
        input  csum,
`endif
        input  mem_en, mem_we, mem_addr, mem_di
    );
endinterface

// File: rtl/mem_sp_stream_ctrl.sv
// -----------------------------------------------------------------------------
// mem_sp_stream_ctrl
//   Initiator-side controller for a single-ported synchronous RAM (1-cycle
//   registered read, write-first). Turns block commands (base, length,
//   direction) into RAM accesses: write blocks consume a valid/ready input
//   stream at up to one word per cycle, read blocks produce a valid/ready
//   output stream with full backpressure through a 4-entry FIFO.
//
//   Ports
//     clk  : clock, rising edge
//     rst  : asynchronous active-high reset
//     bus  : mem_sp_stream_ctrl_if.slave (command, write stream, read stream,
//            done pulse, RAM pins)
//
//   Optional feature
//     MEM_SP_STREAM_CSUM_EN : adds bus.csum, the XOR of every write beat or
//                             popped read beat of the current command.
// -----------------------------------------------------------------------------
module mem_sp_stream_ctrl #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 64
) (
    input logic                 clk,
    input logic                 rst,
    mem_sp_stream_ctrl_if.slave bus
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {IDLE, WR, RD} state_t;

    state_t           state;
    logic [AW-1:0]    ptr;        // next write address / next read address to issue
    logic [AW:0]      remaining;  // WR: beats left, RD: pops left
    logic [AW:0]      to_issue;   // RD: reads not yet issued
    logic             done_r;

    logic             vld_p0;     // a read is presented to the RAM this cycle
    logic [AW-1:0]    addr_p0;
    logic             vld_p1;     // mem_do carries the read presented last cycle

    logic [WIDTH-1:0] fifo_mem [4];
    logic [1:0]       fifo_wp;
    logic [1:0]       fifo_rp;
    logic [2:0]       fifo_cnt;

    logic             accept;
    logic             wr_beat;
    logic             rd_pop;
    logic             issue_go;
    logic [2:0]       outstanding;

    function automatic logic [AW-1:0] next_addr(input logic [AW-1:0] a);
        return (a == AW'(DEPTH - 1)) ? '0 : a + AW'(1);
    endfunction

    assign accept   = bus.cmd_valid && (state == IDLE);
    assign wr_beat  = (state == WR) && bus.wr_valid;
    assign rd_pop   = (fifo_cnt != 3'd0) && bus.rd_ready;

    // Every word that will still land in the FIFO counts against its 4 slots,
    // so issuing only while this is below 4 can never overflow it.
    assign outstanding = fifo_cnt + {2'b00, vld_p0} + {2'b00, vld_p1};
    assign issue_go    = (state == RD) && (to_issue != '0) && (outstanding < 3'd4);

    assign bus.cmd_ready = (state == IDLE);
    assign bus.wr_ready  = (state == WR);
    assign bus.rd_valid  = (fifo_cnt != 3'd0);
    assign bus.rd_data   = (fifo_cnt != 3'd0) ? fifo_mem[fifo_rp] : '0;
    assign bus.done      = done_r;

    // Writes and reads never overlap in time: wr_beat only in WR, vld_p0 only in RD.
    assign bus.mem_en   = wr_beat || vld_p0;
    assign bus.mem_we   = wr_beat;
    assign bus.mem_addr = wr_beat ? ptr : (vld_p0 ? addr_p0 : '0);
    assign bus.mem_di   = wr_beat ? bus.wr_data : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            ptr       <= '0;
            remaining <= '0;
            to_issue  <= '0;
            done_r    <= 1'b0;
            vld_p0    <= 1'b0;
            vld_p1    <= 1'b0;
            fifo_wp   <= '0;
            fifo_rp   <= '0;
            fifo_cnt  <= '0;
        end else begin
            done_r <= 1'b0;

            // ---- stage p0: issue decision -> read presented to RAM ----
            vld_p0 <= issue_go;
            // ---- stage p1: RAM registered read -> mem_do valid ----
            vld_p1 <= vld_p0;
            // ---- stage p2: mem_do captured into FIFO ----
            if (vld_p1) fifo_wp <= fifo_wp + 2'd1;
            if (rd_pop) fifo_rp <= fifo_rp + 2'd1;
            fifo_cnt <= fifo_cnt + {2'b00, vld_p1} - {2'b00, rd_pop};

            case (state)
                IDLE: begin
                    if (accept) begin
                        ptr       <= bus.cmd_base;
                        remaining <= bus.cmd_len;
                        to_issue  <= bus.cmd_len;
                        if (bus.cmd_len == '0)
                            done_r <= 1'b1;
                        else if (bus.cmd_rd)
                            state <= RD;
                        else
                            state <= WR;
                    end
                end
                WR: begin
                    if (wr_beat) begin
                        ptr       <= next_addr(ptr);
                        remaining <= remaining - (AW+1)'(1);
                        if (remaining == (AW+1)'(1)) begin
                            state  <= IDLE;
                            done_r <= 1'b1;
                        end
                    end
                end
                RD: begin
                    if (issue_go) begin
                        ptr      <= next_addr(ptr);
                        to_issue <= to_issue - (AW+1)'(1);
                    end
                    if (rd_pop) begin
                        remaining <= remaining - (AW+1)'(1);
                        if (remaining == (AW+1)'(1)) begin
                            state  <= IDLE;
                            done_r <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Datapath registers carry no reset; their qualifiers (vld_p0, vld_p1,
    // fifo_cnt) are reset instead.
    always_ff @(posedge clk) begin
        if (issue_go) addr_p0 <= ptr;
        if (vld_p1)   fifo_mem[fifo_wp] <= bus.mem_do;
    end

`ifdef MEM_SP_STREAM_CSUM_EN
    logic [WIDTH-1:0] csum_r;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            csum_r <= '0;
        else if (accept)
            csum_r <= '0;
        else if (wr_beat)
            csum_r <= csum_r ^ bus.wr_data;
        else if (rd_pop)
            csum_r <= csum_r ^ fifo_mem[fifo_rp];
    end

    assign bus.csum = csum_r;
`endif

endmodule

// File: tb/tb_mem_sp_stream_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mem_sp_stream_ctrl
//   Bench for mem_sp_stream_ctrl with a behavioural single-ported RAM and a
//   reference model (array image of the RAM plus address/word counters).
//   Checks csum as well when MEM_SP_STREAM_CSUM_EN is defined.
// -----------------------------------------------------------------------------
module tb_mem_sp_stream_ctrl;
    localparam int WIDTH = 8;
    localparam int DEPTH = 64;

    logic clk = 1'b0;
    logic rst;

    mem_sp_stream_ctrl_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

    mem_sp_stream_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Behavioural RAM: registered read, write-first.
    logic [WIDTH-1:0] ram [DEPTH];
    always @(posedge clk) begin
        if (bus.mem_en) begin
            if (bus.mem_we) begin
                ram[bus.mem_addr] <= bus.mem_di;
                bus.mem_do        <= bus.mem_di;
            end else begin
                bus.mem_do <= ram[bus.mem_addr];
            end
        end
    end

    logic [WIDTH-1:0] ref_mem [DEPTH];
    logic [WIDTH-1:0] wbuf [DEPTH];
    logic [WIDTH-1:0] ref_csum;
    int n_chk = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Offer a command at #1 after an edge; returns #1 after the accepting edge.
    task automatic offer_cmd(input bit rd, input int base, input int len);
        bus.cmd_valid = 1'b1;
        bus.cmd_rd    = rd;
        bus.cmd_base  = 6'(base);
        bus.cmd_len   = 7'(len);
        @(negedge clk);
        check("cmd_ready_idle", bus.cmd_ready, 1);
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0;
        ref_csum = '0;
    endtask

    task automatic zero_len_done();
        @(negedge clk);
        check("len0_done", bus.done, 1);
        check("len0_mem_en", bus.mem_en, 0);
        check("len0_cmd_ready", bus.cmd_ready, 1);
        @(posedge clk); #1;
    endtask

    task automatic run_write(input int base, input int len, input int gap_pct);
        int beat = 0;
        int cyc  = 0;
        int p    = base;
        offer_cmd(1'b0, base, len);
        if (len == 0) begin
            zero_len_done();
            return;
        end
        while (beat < len && cyc < 2000) begin
            bus.wr_valid = ($urandom_range(99) >= gap_pct);
            bus.wr_data  = wbuf[beat];
            @(negedge clk);
            check("wr_ready", bus.wr_ready, 1);
            check("wr_no_done", bus.done, 0);
            if (bus.wr_valid) begin
                check("wr_mem_en", bus.mem_en, 1);
                check("wr_mem_we", bus.mem_we, 1);
                check("wr_addr", bus.mem_addr, p);
                check("wr_di", bus.mem_di, wbuf[beat]);
                ref_mem[p] = wbuf[beat];
                ref_csum   = ref_csum ^ wbuf[beat];
                p = (p + 1) % DEPTH;
                beat++;
            end else begin
                check("wr_idle_mem_en", bus.mem_en, 0);
            end
            @(posedge clk); #1;
            cyc++;
        end
        bus.wr_valid = 1'b0;
        check("wr_all_beats", beat, len);
        @(negedge clk);
        check("wr_done", bus.done, 1);
        check("wr_done_idle", bus.cmd_ready, 1);
        check("wr_done_wr_ready", bus.wr_ready, 0);
`ifdef MEM_SP_STREAM_CSUM_EN
        check("wr_csum", bus.csum, ref_csum);
`endif
        @(posedge clk); #1;
    endtask

    task automatic run_read(input int base, input int len, input int stall, input int rdy_pct);
        int popped = 0;
        int issued = 0;
        int cyc    = 0;
        int first  = -1;
        logic [WIDTH-1:0] want;
        offer_cmd(1'b1, base, len);
        if (len == 0) begin
            zero_len_done();
            return;
        end
        while (popped < len && cyc < 2000) begin
            bus.rd_ready = (cyc < stall) ? 1'b0 : ($urandom_range(99) < rdy_pct);
            @(negedge clk);
            // cyc = number of rising edges since the accepting edge
            if (bus.mem_en) begin
                check("rd_mem_we", bus.mem_we, 0);
                check("rd_addr", bus.mem_addr, (base + issued) % DEPTH);
                issued++;
            end
            check("rd_outstanding_le4", (issued - popped) <= 4, 1);
            check("rd_no_done", bus.done, 0);
            if (stall >= 8 && cyc == stall - 1)
                check("rd_stall_issue_cnt", issued, (len < 4) ? len : 4);
            if (bus.rd_valid && first < 0) first = cyc;
            if (bus.rd_valid && bus.rd_ready) begin
                want = ref_mem[(base + popped) % DEPTH];
                check("rd_data", bus.rd_data, want);
                ref_csum = ref_csum ^ want;
                popped++;
            end
            @(posedge clk); #1;
            cyc++;
        end
        bus.rd_ready = 1'b0;
        check("rd_all_popped", popped, len);
        check("rd_first_latency", first, 3);
        check("rd_issue_total", issued, len);
        @(negedge clk);
        check("rd_done", bus.done, 1);
        check("rd_done_rd_valid", bus.rd_valid, 0);
        check("rd_done_mem_en", bus.mem_en, 0);
`ifdef MEM_SP_STREAM_CSUM_EN
        check("rd_csum", bus.csum, ref_csum);
`endif
        @(posedge clk); #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst           = 1'b1;
        bus.cmd_valid = 1'b0;
        bus.cmd_rd    = 1'b0;
        bus.cmd_base  = '0;
        bus.cmd_len   = '0;
        bus.wr_valid  = 1'b0;
        bus.wr_data   = '0;
        bus.rd_ready  = 1'b0;
        ref_csum      = '0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_cmd_ready", bus.cmd_ready, 1);
        check("rst_wr_ready", bus.wr_ready, 0);
        check("rst_rd_valid", bus.rd_valid, 0);
        check("rst_done", bus.done, 0);
        check("rst_mem_en", bus.mem_en, 0);
        check("rst_mem_we", bus.mem_we, 0);
        check("rst_mem_addr", bus.mem_addr, 0);
        check("rst_mem_di", bus.mem_di, 0);
        check("rst_rd_data", bus.rd_data, 0);
`ifdef MEM_SP_STREAM_CSUM_EN
        check("rst_csum", bus.csum, 0);
`endif
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        // zero-length commands in both directions
        run_write(10, 0, 0);
        run_read(10, 0, 0, 100);

        // fill the whole RAM (len = DEPTH, wrapping base)
        for (int i = 0; i < DEPTH; i++) wbuf[i] = 8'($urandom);
        run_write(17, DEPTH, 20);

        // directed: write/read 0xA1..0xA4 at 5
        for (int i = 0; i < 4; i++) wbuf[i] = 8'(8'hA1 + i);
        run_write(5, 4, 0);
        run_read(5, 4, 0, 100);

        // backpressure: 10 stalled cycles on an 8-word read
        run_read(0, 8, 10, 100);

        // address wrap at the top of the RAM
        for (int i = 0; i < 4; i++) wbuf[i] = 8'($urandom);
        run_write(62, 4, 0);
        run_read(62, 4, 0, 100);

        // randomized commands
        for (int t = 0; t < 30; t++) begin
            int base;
            int len;
            base = $urandom_range(DEPTH - 1);
            len  = ($urandom_range(9) == 0) ? DEPTH : $urandom_range(20);
            if ($urandom_range(1) == 0) begin
                for (int i = 0; i < DEPTH; i++) wbuf[i] = 8'($urandom);
                run_write(base, len, $urandom_range(50));
            end else begin
                run_read(base, len, $urandom_range(6), $urandom_range(30, 100));
            end
        end

        // reset in the middle of a read
        offer_cmd(1'b1, 20, 8);
        bus.rd_ready = 1'b0;
        repeat (4) begin
            @(posedge clk); #1;
        end
        check("midrd_mem_en_before", bus.mem_en, 1);
        check("midrd_rd_valid_before", bus.rd_valid, 1);
        rst = 1'b1;
        #1;
        check("midrd_mem_en", bus.mem_en, 0);
        check("midrd_mem_we", bus.mem_we, 0);
        check("midrd_rd_valid", bus.rd_valid, 0);
        check("midrd_done", bus.done, 0);
        check("midrd_cmd_ready", bus.cmd_ready, 1);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("postrst_done", bus.done, 0);
        check("postrst_rd_valid", bus.rd_valid, 0);
        @(posedge clk); #1;

        // earlier contents survive the reset; then fresh write/read of 0xA1..0xA4
        run_read(62, 4, 0, 100);
        for (int i = 0; i < 4; i++) wbuf[i] = 8'(8'hA1 + i);
        run_write(5, 4, 0);
        run_read(5, 4, 0, 100);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
